// File: rtl/timer_pkg.sv
// timer_pkg
// Shared definitions for the MM:SS countdown timer: state encoding of the
// run/pause FSM, count field width, seconds wrap value and a clamp helper
// used when a preset is loaded.
package timer_pkg;

    localparam int CNT_W = 6;

    localparam logic [CNT_W-1:0] SEC_MAX = 6'd59;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Saturate a loaded preset to the highest legal value of its field.
    function automatic logic [CNT_W-1:0] clamp_cnt(input logic [CNT_W-1:0] val,
                                                   input logic [CNT_W-1:0] lim);
        return (val > lim) ? lim : val;
    endfunction

endpackage

// File: rtl/counter_sec_down.sv
// counter_sec_down
// One 6-bit down-counting field of the countdown timer (seconds or minutes).
// Loads a preset clamped to MAX, decrements on i_dec, and when WRAP is set
// wraps 0 -> MAX and flags the wrap on o_borrow in the same cycle as the
// decrement request (the parent registers it). With WRAP clear the field
// simply holds at zero.
//
// Ports:
//   i_clk       clock, rising edge
//   i_rst       asynchronous active-high reset, clears the field
//   i_load      synchronous load of i_load_val (clamped to MAX)
//   i_load_val  preset value
//   i_dec       decrement request (ignored while i_load is high)
//   o_count     registered field value
//   o_borrow    combinational: decrement requested while field is zero
module counter_sec_down
    import timer_pkg::*;
#(
    parameter logic [CNT_W-1:0] MAX  = SEC_MAX,
    parameter bit               WRAP = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_count,
    output logic             o_borrow
);

    logic [CNT_W-1:0] r_count;
    logic             w_zero;

    assign w_zero   = (r_count == '0);
    assign o_count  = r_count;
    assign o_borrow = WRAP && i_dec && !i_load && w_zero;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= clamp_cnt(i_load_val, MAX);
        end else if (i_dec) begin
            if (w_zero) begin
                if (WRAP) begin
                    r_count <= MAX;
                end
            end else begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/countdown_mmss.sv
// countdown_mmss
// Minutes:seconds countdown timer. A preset MM:SS is loaded, started, and
// then decremented once per one-second tick. borrow_sec pulses when seconds
// wrap 00->59, done pulses for one cycle together with the first 00:00
// reading. The prescaler divides enabled cycles down to ticks and only
// advances while running.
//
// Ports:
//   clock       system clock, rising edge
//   reset_tmr   asynchronous active-high reset
//   enable_tmr  tick enable shared with the time-of-day counters
//   load_tmr    synchronous preset load (highest priority after reset)
//   data_min    preset minutes (clamped to MAX_MIN)
//   data_sec    preset seconds (clamped to 59)
//   start       run request (level)
//   stop        pause request (level, wins over start)
//   count_min   current minutes
//   count_sec   current seconds
//   borrow_sec  one-cycle pulse on seconds wrap
//   done        one-cycle pulse on reaching 00:00
//   running     high while in RUN
//
// state | meaning
// IDLE  | preset loaded or after reset, count held, waiting for start
// RUN   | counting down on each tick
// PAUSE | stopped mid-count, count and prescaler held
// DONE  | reached 00:00, only load or reset leaves
module countdown_mmss
    import timer_pkg::*;
#(
    parameter int MAX_MIN  = 59,
    parameter int TICK_DIV = 1
) (
    input  logic             clock,
    input  logic             reset_tmr,
    input  logic             enable_tmr,
    input  logic             load_tmr,
    input  logic [CNT_W-1:0] data_min,
    input  logic [CNT_W-1:0] data_sec,
    input  logic             start,
    input  logic             stop,
    output logic [CNT_W-1:0] count_min,
    output logic [CNT_W-1:0] count_sec,
    output logic             borrow_sec,
    output logic             done,
    output logic             running
);

    localparam int               PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] MIN_MAX    = CNT_W'(MAX_MIN);

    state_t           r_state;
    state_t           w_next_state;
    logic [PW-1:0]    r_presc;
    logic             r_done;
    logic             r_borrow;
    logic             r_running;

    logic             w_tick;
    logic             w_presc_adv;
    logic             w_dec_sec;
    logic             w_dec_min;
    logic             w_done_nxt;
    logic             w_zero;
    logic             w_last_sec;
    logic             w_sec_borrow;
    logic             w_min_borrow;
    logic [CNT_W-1:0] w_sec;
    logic [CNT_W-1:0] w_min;

    assign w_tick     = enable_tmr && (r_presc == PRESC_LAST);
    assign w_zero     = (w_min == '0) && (w_sec == '0);
    assign w_last_sec = (w_min == '0) && (w_sec == CNT_W'(1));
    // Minutes step down exactly when seconds are about to wrap.
    assign w_dec_min  = w_dec_sec && (w_sec == '0);

    counter_sec_down #(
        .MAX  (SEC_MAX),
        .WRAP (1'b1)
    ) u_sec (
        .i_clk      (clock),
        .i_rst      (reset_tmr),
        .i_load     (load_tmr),
        .i_load_val (data_sec),
        .i_dec      (w_dec_sec),
        .o_count    (w_sec),
        .o_borrow   (w_sec_borrow)
    );

    counter_sec_down #(
        .MAX  (MIN_MAX),
        .WRAP (1'b0)
    ) u_min (
        .i_clk      (clock),
        .i_rst      (reset_tmr),
        .i_load     (load_tmr),
        .i_load_val (data_min),
        .i_dec      (w_dec_min),
        .o_count    (w_min),
        .o_borrow   (w_min_borrow)
    );

    always_ff @(posedge clock or posedge reset_tmr) begin
        if (reset_tmr) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_presc_adv  = 1'b0;
        w_dec_sec    = 1'b0;
        w_done_nxt   = 1'b0;
        if (load_tmr) begin
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!stop && start) begin
                        if (w_zero) begin
                            w_next_state = DONE;
                            w_done_nxt   = 1'b1;
                        end else begin
                            w_next_state = RUN;
                        end
                    end
                end
                RUN: begin
                    if (stop) begin
                        w_next_state = PAUSE;
                    end else if (w_zero) begin
                        // Unreachable in normal operation; never count below zero.
                        w_next_state = DONE;
                    end else begin
                        w_presc_adv = enable_tmr;
                        if (w_tick) begin
                            w_dec_sec = 1'b1;
                            if (w_last_sec) begin
                                w_next_state = DONE;
                                w_done_nxt   = 1'b1;
                            end
                        end
                    end
                end
                PAUSE: begin
                    if (!stop && start) begin
                        w_next_state = RUN;
                    end
                end
                DONE: begin
                    w_next_state = DONE;
                end
                default: begin
                    w_next_state = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset_tmr) begin
        if (reset_tmr) begin
            r_presc <= '0;
        end else if (load_tmr) begin
            r_presc <= '0;
        end else if (w_presc_adv) begin
            r_presc <= (r_presc == PRESC_LAST) ? '0 : r_presc + PW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset_tmr) begin
        if (reset_tmr) begin
            r_done    <= 1'b0;
            r_borrow  <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_done    <= w_done_nxt;
            r_borrow  <= w_sec_borrow;
            r_running <= (w_next_state == RUN);
        end
    end

    assign count_min  = w_min;
    assign count_sec  = w_sec;
    assign borrow_sec = r_borrow;
    assign done       = r_done;
    assign running    = r_running;

    // Minutes never wrap, so their borrow output carries no information.
    logic w_unused;
    assign w_unused = w_min_borrow;

endmodule

// File: tb/tb_countdown_mmss.sv
module tb_countdown_mmss;
    import timer_pkg::*;

    logic       clock = 1'b0;
    logic       reset_tmr;
    logic       enable_tmr;
    logic       load_tmr;
    logic [5:0] data_min;
    logic [5:0] data_sec;
    logic       start;
    logic       stop;
    logic [5:0] count_min;
    logic [5:0] count_sec;
    logic       borrow_sec;
    logic       done;
    logic       running;

    int n_cmp = 0;
    int n_err = 0;

    countdown_mmss #(.MAX_MIN(59), .TICK_DIV(1)) dut (
        .clock      (clock),
        .reset_tmr  (reset_tmr),
        .enable_tmr (enable_tmr),
        .load_tmr   (load_tmr),
        .data_min   (data_min),
        .data_sec   (data_sec),
        .start      (start),
        .stop       (stop),
        .count_min  (count_min),
        .count_sec  (count_sec),
        .borrow_sec (borrow_sec),
        .done       (done),
        .running    (running)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       ld;
        logic [5:0] dmin;
        logic [5:0] dsec;
        logic       st;
        logic       sp;
        logic       en;
        logic [5:0] emin;
        logic [5:0] esec;
        logic       eb;
        logic       ed;
        logic       er;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(input logic ld, input logic [5:0] dmin, input logic [5:0] dsec,
                                input logic st, input logic sp, input logic en,
                                input logic [5:0] emin, input logic [5:0] esec,
                                input logic eb, input logic ed, input logic er);
        vec_t v;
        v.ld = ld; v.dmin = dmin; v.dsec = dsec; v.st = st; v.sp = sp; v.en = en;
        v.emin = emin; v.esec = esec; v.eb = eb; v.ed = ed; v.er = er;
        return v;
    endfunction

    task automatic chk(input string name, input logic [5:0] emin, input logic [5:0] esec,
                       input logic eb, input logic ed, input logic er);
        logic [14:0] act;
        logic [14:0] exp;
        act = {count_min, count_sec, borrow_sec, done, running};
        exp = {emin, esec, eb, ed, er};
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d:%0d b=%0b d=%0b r=%0b, want %0d:%0d b=%0b d=%0b r=%0b",
                     name, count_min, count_sec, borrow_sec, done, running,
                     emin, esec, eb, ed, er);
        end
    endtask

    task automatic chk_state(input string name, input state_t exp);
        n_cmp++;
        if (dut.r_state !== exp) begin
            n_err++;
            $display("FAIL %s: state got %0d, want %0d", name, dut.r_state, exp);
        end
    endtask

    task automatic step(input logic ld, input logic [5:0] dm, input logic [5:0] ds,
                        input logic st, input logic sp, input logic en);
        @(negedge clock);
        load_tmr   = ld;
        data_min   = dm;
        data_sec   = ds;
        start      = st;
        stop       = sp;
        enable_tmr = en;
        @(posedge clock);
        #1;
    endtask

    task automatic run_vec(input int i);
        step(vecs[i].ld, vecs[i].dmin, vecs[i].dsec, vecs[i].st, vecs[i].sp, vecs[i].en);
        chk($sformatf("vec%0d", i), vecs[i].emin, vecs[i].esec, vecs[i].eb, vecs[i].ed, vecs[i].er);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // countdown head: load 01:02, start, three ticks through the borrow
        vecs[0]  = mk(1, 1, 2, 0, 0, 1,   1, 2,  0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 1, 0, 1,   1, 2,  0, 0, 1);
        vecs[2]  = mk(0, 0, 0, 0, 0, 1,   1, 1,  0, 0, 1);
        vecs[3]  = mk(0, 0, 0, 0, 0, 1,   1, 0,  0, 0, 1);
        vecs[4]  = mk(0, 0, 0, 0, 0, 1,   0, 59, 1, 0, 1);
        vecs[5]  = mk(0, 0, 0, 0, 0, 1,   0, 58, 0, 0, 1);
        // clamp
        vecs[6]  = mk(1, 63, 62, 0, 0, 1, 59, 59, 0, 0, 0);
        vecs[7]  = mk(0, 0, 0, 0, 0, 1,   59, 59, 0, 0, 0);
        // zero start
        vecs[8]  = mk(1, 0, 0, 0, 0, 1,   0, 0,  0, 0, 0);
        vecs[9]  = mk(0, 0, 0, 1, 0, 1,   0, 0,  0, 1, 0);
        vecs[10] = mk(0, 0, 0, 0, 0, 1,   0, 0,  0, 0, 0);
        vecs[11] = mk(0, 0, 0, 1, 0, 1,   0, 0,  0, 0, 0);
        vecs[12] = mk(0, 0, 0, 0, 0, 1,   0, 0,  0, 0, 0);
        vecs[13] = mk(0, 0, 0, 1, 0, 1,   0, 0,  0, 0, 0);
        vecs[14] = mk(0, 0, 0, 1, 1, 1,   0, 0,  0, 0, 0);

        reset_tmr  = 1'b1;
        enable_tmr = 1'b0;
        load_tmr   = 1'b0;
        data_min   = '0;
        data_sec   = '0;
        start      = 1'b0;
        stop       = 1'b0;
        #8;
        chk("reset_outputs", 0, 0, 0, 0, 0);
        chk_state("reset_state", IDLE);
        #4;
        reset_tmr = 1'b0;

        // full countdown
        for (int i = 0; i <= 5; i++) run_vec(i);
        for (int k = 1; k <= 57; k++) begin
            step(0, 0, 0, 0, 0, 1);
            chk($sformatf("countdown_%0d", 58 - k), 0, 6'(58 - k), 0, 0, 1);
        end
        step(0, 0, 0, 0, 0, 1);
        chk("reach_zero_done", 0, 0, 0, 1, 0);
        chk_state("state_done", DONE);
        step(0, 0, 0, 0, 0, 1);
        chk("done_one_cycle", 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 1);
        chk("done_ignores_start", 0, 0, 0, 0, 0);

        // clamp
        for (int i = 6; i <= 7; i++) run_vec(i);
        chk_state("clamp_state_idle", IDLE);

        // enable gating
        step(1, 0, 41, 0, 0, 1);
        chk("gate_load", 0, 41, 0, 0, 0);
        step(0, 0, 0, 1, 0, 1);
        chk("gate_start", 0, 41, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        chk("gate_tick", 0, 40, 0, 0, 1);
        for (int k = 0; k < 20; k++) begin
            step(0, 0, 0, 0, 0, 0);
            chk($sformatf("gate_hold_%0d", k), 0, 40, 0, 0, 1);
        end
        step(0, 0, 0, 0, 0, 1);
        chk("gate_resume", 0, 39, 0, 0, 1);

        // pause and priority
        for (int k = 1; k <= 9; k++) begin
            step(0, 0, 0, 0, 0, 1);
            chk($sformatf("to30_%0d", 39 - k), 0, 6'(39 - k), 0, 0, 1);
        end
        step(0, 0, 0, 1, 1, 1);
        chk("startstop_pause", 0, 30, 0, 0, 0);
        chk_state("state_pause", PAUSE);
        for (int k = 0; k < 10; k++) begin
            step(0, 0, 0, 0, 0, 1);
            chk($sformatf("pause_hold_%0d", k), 0, 30, 0, 0, 0);
        end
        step(0, 0, 0, 1, 1, 1);
        chk("pause_startstop_stays", 0, 30, 0, 0, 0);
        step(0, 0, 0, 1, 0, 1);
        chk("pause_resume", 0, 30, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        chk("resume_tick", 0, 29, 0, 0, 1);

        // zero start
        for (int i = 8; i <= 14; i++) run_vec(i);

        // async reset mid-run
        step(1, 0, 46, 0, 0, 1);
        chk("rst_load", 0, 46, 0, 0, 0);
        step(0, 0, 0, 1, 0, 1);
        chk("rst_start", 0, 46, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        chk("rst_at45", 0, 45, 0, 0, 1);
        #2;
        reset_tmr = 1'b1;
        #1;
        chk("rst_immediate", 0, 0, 0, 0, 0);
        chk_state("rst_state_idle", IDLE);
        start = 1'b1;
        @(posedge clock);
        #1;
        chk("rst_held_tick", 0, 0, 0, 0, 0);
        @(negedge clock);
        reset_tmr = 1'b0;
        start     = 1'b0;
        step(0, 0, 0, 0, 0, 1);
        chk("rst_after_release", 0, 0, 0, 0, 0);
        chk_state("rst_release_idle", IDLE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
